// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    ERR
  } lsu_state_t;

  localparam int unsigned DMEM_DEPTH = 16;
  localparam int unsigned DMEM_IDX_W = 5;
  localparam int unsigned IDX_LO     = 2;
  localparam int unsigned IDX_HI     = 5;

endpackage

// File: rtl/dmem_lsu_addr_chk.sv
// Combinational byte-address to word-index conversion with alignment/range check.
module dmem_lsu_addr_chk
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [DMEM_IDX_W-1:0] idx,
  output logic                  err
);

  always_comb begin
    idx                   = '0;
    idx[IDX_HI-IDX_LO:0]  = addr[IDX_HI:IDX_LO];
    err                   = (|addr[IDX_LO-1:0]) | (|addr[ADDR_W-1:IDX_HI+1]);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the 16x32 data memory with a registered read port.
// Optional address checking (misaligned / out-of-range -> error response): DMEM_LSU_ADDR_CHECK_EN.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DMEM_IDX_W-1:0] mem_wr_addr,
  output logic [DMEM_IDX_W-1:0] mem_rd_addr,
  output logic                  mem_reg_wr,
  output logic [DATA_W-1:0]     mem_wr_din,
  input  logic [DATA_W-1:0]     mem_rd_dat
);

  if (DEPTH != DMEM_DEPTH) begin : g_depth_chk
    $error("dmem_lsu: DEPTH must equal DMEM_DEPTH");
  end

  lsu_state_t            state;
  logic                  accept;
  logic [DMEM_IDX_W-1:0] req_idx;
  logic                  req_bad;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef DMEM_LSU_ADDR_CHECK_EN
  dmem_lsu_addr_chk #(
    .ADDR_W(ADDR_W)
  ) u_addr_chk (
    .addr(req_addr),
    .idx (req_idx),
    .err (req_bad)
  );
`else
  logic unused_addr_bits;

  always_comb begin
    req_idx                  = '0;
    req_idx[IDX_HI-IDX_LO:0] = req_addr[IDX_HI:IDX_LO];
  end
  assign req_bad          = 1'b0;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_HI+1], req_addr[IDX_LO-1:0]};
  assign rsp_err          = 1'b0;
`endif

  // The memory-port registers double as the latched request: they are loaded
  // at acceptance so the access appears in the cycle right after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_reg_wr  <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_din  <= '0;
`ifdef DMEM_LSU_ADDR_CHECK_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      rsp_valid  <= 1'b0;
      mem_reg_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              state <= ERR;
            end else if (req_we) begin
              state       <= WR;
              mem_reg_wr  <= 1'b1;
              mem_wr_addr <= req_idx;
              mem_wr_din  <= req_wdata;
            end else begin
              state       <= RD;
              mem_rd_addr <= req_idx;
            end
          end
        end
        WR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
`ifdef DMEM_LSU_ADDR_CHECK_EN
          rsp_err   <= 1'b0;
`endif
          state     <= IDLE;
        end
        RD: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_rd_dat;
`ifdef DMEM_LSU_ADDR_CHECK_EN
          rsp_err   <= 1'b0;
`endif
          state     <= IDLE;
        end
`ifdef DMEM_LSU_ADDR_CHECK_EN
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
